// File: rtl/dds_multi.sv
// Multi-channel DDS: NCH phase accumulators, per-channel wave/step/phase/amp, shadow config committed on sync.
// Latency: dout reflects the accumulator value two clock edges earlier; dout_valid follows the first sync by two edges.
// Backpressure: cfg_ready drops for the one cycle after a sync; dds_en=0 freezes accumulators and pipeline.
module dds_multi #(
    parameter int NCH     = 3,
    parameter int PHASE_W = 16,
    parameter int ADDR    = 10,
    parameter int WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dds_en,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [$clog2(NCH):0]     cfg_ch,
    input  logic [PHASE_W-1:0]       cfg_step,
    input  logic [PHASE_W-1:0]       cfg_phase,
    input  logic [1:0]               cfg_wave,
    input  logic [1:0]               cfg_amp,
    output logic                     cfg_err,
    input  logic                     sync,
    output logic [NCH*WIDTH-1:0]     dout,
    output logic                     dout_valid
);
    localparam int CH_W = $clog2(NCH) + 1;
    localparam longint LP_N = longint'(1) <<< ADDR;
    localparam longint LP_QTR = LP_N / 4;
    localparam longint LP_MID = longint'(1) <<< (WIDTH - 1);
    localparam longint LP_PI_Q30 = 64'sd3373259426;
    localparam logic signed [WIDTH:0] LP_MID_S = (WIDTH+1)'(2**(WIDTH-1));

    // Sine sample in Q30 fixed point: quarter-wave folding plus Taylor series, then round to nearest
    function automatic logic [WIDTH-1:0] sin_entry(input int a);
        longint q, idx, x, x2, term, s, v;
        q   = longint'(a) / LP_QTR;
        idx = longint'(a) % LP_QTR;
        if (q == 1 || q == 3) idx = LP_QTR - idx;
        x    = (LP_PI_Q30 * 2 * idx) / LP_N;
        x2   = (x * x) >>> 30;
        term = x;
        s    = x;
        for (int k = 1; k <= 12; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        if (q >= 2) s = -s;
        v = ((LP_MID - 1) * s + (LP_MID <<< 30) + (longint'(1) <<< 29)) >>> 30;
        return v[WIDTH-1:0];
    endfunction

    // Amplitude: arithmetic shift of the signed offset from mid-scale
    function automatic logic [WIDTH-1:0] atten(input logic [WIDTH-1:0] raw, input logic [1:0] amp);
        logic signed [WIDTH:0] d;
        d = $signed({1'b0, raw}) - LP_MID_S;
        d = d >>> amp;
        d = d + LP_MID_S;
        return d[WIDTH-1:0];
    endfunction

    logic [PHASE_W-1:0] r_sh_step  [NCH];
    logic [PHASE_W-1:0] r_sh_phase [NCH];
    logic [1:0]         r_sh_wave  [NCH];
    logic [1:0]         r_sh_amp   [NCH];
    logic [PHASE_W-1:0] r_step     [NCH];
    logic [1:0]         r_wave     [NCH];
    logic [1:0]         r_amp      [NCH];
    logic [PHASE_W-1:0] r_acc      [NCH];
    logic [ADDR-1:0]    r_addr     [NCH];
    logic [1:0]         r_wave1    [NCH];
    logic [1:0]         r_amp1     [NCH];
    logic [WIDTH-1:0]   r_dout     [NCH];
    logic [WIDTH-1:0]   w_raw      [NCH];
    logic [WIDTH-1:0]   w_next     [NCH];
    logic [WIDTH-1:0]   w_sin_rom  [2**ADDR];
    logic               r_sync_d, r_synced, r_v1, r_v2, r_cfg_err;
    logic               w_hs, w_wr_ok;

    for (genvar i = 0; i < 2**ADDR; i++) begin : g_sin
        localparam logic [WIDTH-1:0] LP_V = sin_entry(i);
        assign w_sin_rom[i] = LP_V;
    end

    assign cfg_ready  = !reset && !r_sync_d;
    assign w_hs       = cfg_valid && cfg_ready;
    assign w_wr_ok    = w_hs && (cfg_ch < CH_W'(NCH));
    assign cfg_err    = r_cfg_err;
    assign dout_valid = r_v2;

    for (genvar c = 0; c < NCH; c++) begin : g_out
        assign dout[c*WIDTH +: WIDTH] = r_dout[c];
    end

    // Shadow config: accepted writes to an existing channel land here only
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_sh_step[c]  <= '0;
                r_sh_phase[c] <= '0;
                r_sh_wave[c]  <= '0;
                r_sh_amp[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_wr_ok && cfg_ch == CH_W'(c)) begin
                    r_sh_step[c]  <= cfg_step;
                    r_sh_phase[c] <= cfg_phase;
                    r_sh_wave[c]  <= cfg_wave;
                    r_sh_amp[c]   <= cfg_amp;
                end
            end
        end
    end

    // Active config and accumulators: sync commits the pre-write shadow and reloads phase, overriding dds_en
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_step[c] <= '0;
                r_wave[c] <= '0;
                r_amp[c]  <= '0;
                r_acc[c]  <= '0;
            end
        end else if (sync) begin
            for (int c = 0; c < NCH; c++) begin
                r_step[c] <= r_sh_step[c];
                r_wave[c] <= r_sh_wave[c];
                r_amp[c]  <= r_sh_amp[c];
                r_acc[c]  <= r_sh_phase[c];
            end
        end else if (dds_en) begin
            for (int c = 0; c < NCH; c++) begin
                r_acc[c] <= r_acc[c] + r_step[c];
            end
        end
    end

    // Handshake bookkeeping: ready hole after sync, error pulse for out-of-range channel, first-sync flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_d  <= 1'b0;
            r_cfg_err <= 1'b0;
            r_synced  <= 1'b0;
        end else begin
            r_sync_d  <= sync;
            r_cfg_err <= w_hs && !w_wr_ok;
            r_synced  <= r_synced || sync;
        end
    end

    // Waveform generation and attenuation for stage 2
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_raw[c] = '0;
            case (r_wave1[c])
                2'd0: w_raw[c] = w_sin_rom[r_addr[c]];
                2'd1: w_raw[c] = r_addr[c][ADDR-1] ? ~r_addr[c][ADDR-2 -: WIDTH]
                                                   :  r_addr[c][ADDR-2 -: WIDTH];
                2'd2: w_raw[c] = r_addr[c][ADDR-1] ? '0 : '1;
                default: w_raw[c] = r_addr[c][ADDR-1 -: WIDTH];
            endcase
            w_next[c] = atten(w_raw[c], r_amp1[c]);
        end
    end

    // Two-stage output pipeline, frozen together with the accumulators
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_addr[c]  <= '0;
                r_wave1[c] <= '0;
                r_amp1[c]  <= '0;
                r_dout[c]  <= '0;
            end
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else if (dds_en) begin
            for (int c = 0; c < NCH; c++) begin
                r_addr[c]  <= r_acc[c][PHASE_W-1 -: ADDR];
                r_wave1[c] <= r_wave[c];
                r_amp1[c]  <= r_amp[c];
                r_dout[c]  <= w_next[c];
            end
            r_v1 <= r_synced;
            r_v2 <= r_v1;
        end
    end
endmodule
